// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_e : sequencer state encoding
//   REG_IDX_W    : register-index width
//   REG_X0       : hard-wired zero register index (never a hazard source)
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction currently in ID.
//   id_rs1_address/id_rs2_address : sources of the ID instruction
//   id_uses_rs1/id_uses_rs2       : source-valid qualifiers
//   ex_rd_address, ex_reg_wren    : destination held in ID/EX
//   ex_is_load                    : ID/EX write data comes from RAM
//   load_use                      : hazard present this cycle
module load_use_detector
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_address,
  input  logic [REG_IDX_W-1:0] id_rs2_address,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd_address,
  input  logic                 ex_reg_wren,
  input  logic                 ex_is_load,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1_address == ex_rd_address);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_address == ex_rd_address);
  // x0 is never really written, so a load targeting it cannot create a hazard
  assign load_use = ex_is_load && ex_reg_wren && (ex_rd_address != REG_X0)
                    && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core. Drives pipeline-register
// enables and the IF/ID flush / ID/EX bubble controls, sequences
// multi-cycle EX operations with a timeout, and counts stall cycles.
//   clk, reset_n                 : clock, async active-low reset
//   id_*, ex_rd_address,
//   ex_reg_wren, ex_is_load      : load-use hazard inputs
//   ex_redirect                  : taken branch/jump resolved in EX
//   ex_mc_op, mc_done            : multi-cycle op handshake
//   pc_wren .. ex_mem_wren       : pipeline register enables
//   if_id_flush, id_ex_bubble    : squash controls
//   mc_start                     : start pulse to multi-cycle unit
//   mc_error                     : sticky multi-cycle timeout flag
//   stall_count                  : saturating count of cycles with pc_wren=0
//
// state    | meaning
// RUN      | normal flow; resolves mc op, redirect, load-use (in that order)
// MC_WAIT  | pipeline frozen until mc_done or timeout
// REDIRECT | extra squash cycles covering instruction-memory latency
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MC_TIMEOUT       = 64,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] id_rs1_address,
  input  logic [REG_IDX_W-1:0] id_rs2_address,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd_address,
  input  logic                 ex_reg_wren,
  input  logic                 ex_is_load,
  input  logic                 ex_redirect,
  input  logic                 ex_mc_op,
  input  logic                 mc_done,
  output logic                 pc_wren,
  output logic                 if_id_wren,
  output logic                 if_id_flush,
  output logic                 id_ex_wren,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_wren,
  output logic                 mc_start,
  output logic                 mc_error,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [15:0] MC_TIMEOUT_L = 16'(MC_TIMEOUT);
  localparam logic [2:0]  REDIRECT_L   = 3'(REDIRECT_BUBBLES);

  ctrl_state_e state, state_nxt;
  logic [15:0] mc_cnt, mc_cnt_nxt;
  logic [2:0]  redir_cnt, redir_cnt_nxt;
  logic        set_error;
  logic        load_use;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic flush, bubble, start;

  load_use_detector u_load_use_detector (
    .id_rs1_address (id_rs1_address),
    .id_rs2_address (id_rs2_address),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd_address  (ex_rd_address),
    .ex_reg_wren    (ex_reg_wren),
    .ex_is_load     (ex_is_load),
    .load_use       (load_use)
  );

  always_comb begin
    state_nxt     = state;
    mc_cnt_nxt    = mc_cnt;
    redir_cnt_nxt = redir_cnt;
    set_error     = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    flush         = 1'b0;
    bubble        = 1'b0;
    start         = 1'b0;
    case (state)
      RUN: begin
        if (ex_mc_op) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          start      = 1'b1;
          state_nxt  = MC_WAIT;
          mc_cnt_nxt = 16'd1;
        end else if (ex_redirect) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (REDIRECT_L != 3'd0) begin
            state_nxt     = REDIRECT;
            redir_cnt_nxt = REDIRECT_L;
          end
        end else if (load_use) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          bubble   = 1'b1;
        end
      end
      MC_WAIT: begin
        // done beats timeout when both land in the same cycle
        if (mc_done) begin
          state_nxt = RUN;
        end else if (mc_cnt >= MC_TIMEOUT_L) begin
          set_error = 1'b1;
          state_nxt = RUN;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mc_cnt_nxt = mc_cnt + 16'd1;
        end
      end
      REDIRECT: begin
        flush         = 1'b1;
        bubble        = 1'b1;
        redir_cnt_nxt = redir_cnt - 3'd1;
        if (redir_cnt <= 3'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      mc_cnt      <= '0;
      redir_cnt   <= '0;
      mc_error    <= 1'b0;
      stall_count <= '0;
    end else begin
      state     <= state_nxt;
      mc_cnt    <= mc_cnt_nxt;
      redir_cnt <= redir_cnt_nxt;
      if (set_error) mc_error <= 1'b1;
      if (!pc_en && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

  // Everything is forced inactive while reset is held, independent of the clock
  assign pc_wren      = reset_n & pc_en;
  assign if_id_wren   = reset_n & if_id_en;
  assign id_ex_wren   = reset_n & id_ex_en;
  assign ex_mem_wren  = reset_n & ex_mem_en;
  assign if_id_flush  = reset_n & flush;
  assign id_ex_bubble = reset_n & bubble;
  assign mc_start     = reset_n & start;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives the wren enables of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Drives bubble/flush controls that zero the control fields (reg_wren, ram_wren, next_pc_src) entering IF/ID and ID/EX.
- Resolves load-use hazards, taken-branch/jump redirects and multi-cycle EX operations (divider/FPU), and keeps a stall-cycle performance counter.

Parameters:
REDIRECT_BUBBLES, 1, extra squash cycles after a redirect to cover instruction-memory read latency (0..7)
MC_TIMEOUT, 64, max cycles waited for mc_done before abort (2..65535)
CNT_WIDTH, 32, width of stall_count

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
id_rs1_address  in  5  rs1 of instruction in ID
id_rs2_address  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd_address  in  5  rd held in ID/EX
ex_reg_wren  in  1  ID/EX reg_wren
ex_is_load  in  1  ID/EX reg_write_data_src selects RAM
ex_redirect  in  1  EX resolved taken branch/jump (next_pc_src != sequential)
ex_mc_op  in  1  ID/EX holds a multi-cycle op
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
pc_wren  out  1  PC register enable
if_id_wren  out  1  IF/ID enable
if_id_flush  out  1  squash IF/ID input to NOP
id_ex_wren  out  1  ID/EX enable
id_ex_bubble  out  1  zero control fields into ID/EX
ex_mem_wren  out  1  EX/MEM enable
mc_start  out  1  start pulse to multi-cycle unit
mc_error  out  1  sticky timeout flag
stall_count  out  CNT_WIDTH  cycles with pc_wren=0, saturating

Behaviour:
- States: RUN, MC_WAIT, REDIRECT. All enables/flushes are combinational from state+inputs; state, counters and mc_error are registered.
- Reset (reset_n low, async): state=RUN, redirect counter=0, mc counter=0, mc_error=0, stall_count=0. All wren=0, flush/bubble=0, mc_start=0 while asserted. Reset takes effect immediately, including mid-MC_WAIT.
- Default in RUN with no event: all wren=1, flush/bubble=0.
- RUN priority, highest first:
  1. ex_mc_op: mc_start=1 for this cycle only; all four wren=0; go MC_WAIT; mc counter=1.
  2. ex_redirect: pc_wren=1 (target loads), if_id_flush=1, id_ex_bubble=1, if_id_wren=id_ex_wren=ex_mem_wren=1. If REDIRECT_BUBBLES>0, go REDIRECT with counter=REDIRECT_BUBBLES; else stay RUN.
  3. Load-use: ex_is_load & ex_reg_wren & ex_rd_address!=0 & ((id_uses_rs1 & id_rs1_address==ex_rd_address) | (id_uses_rs2 & id_rs2_address==ex_rd_address)). Response: pc_wren=0, if_id_wren=0, id_ex_wren=1, id_ex_bubble=1, ex_mem_wren=1. Stay RUN; exactly one stall cycle per hazard.
- MC_WAIT:
  - All wren=0; mc counter increments.
  - mc_done=1: all wren=1 this cycle, go RUN.
  - Counter reaches MC_TIMEOUT without mc_done: set mc_error, all wren=1 (EX result is garbage but the pipeline advances), go RUN.
  - mc_done and timeout in the same cycle: done wins, mc_error not set.
  - ex_redirect is ignored in MC_WAIT.
- REDIRECT:
  - pc_wren=1, if_id_flush=1, id_ex_bubble=1, all other wren=1.
  - Counter decrements; at 1, go RUN.
  - A new ex_redirect here cannot occur (EX holds bubbles) and is ignored.
  - Load-use is not evaluated (ID is flushed).
- stall_count: +1 on every cycle with pc_wren=0 outside reset; saturates at all-ones, no wrap.
- mc_error: cleared only by reset.

Decomposition:
- Shared package pipeline_ctrl_pkg: state encoding constants (RUN=2'd0, MC_WAIT=2'd1, REDIRECT=2'd2), register-index width 5, x0 index constant.
- One natural sub-module: load_use_detector (pure combinational hazard compare). The rest, FSM and counters, stays in this module.

Test Plan:
- ex_is_load=1, ex_reg_wren=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_wren=0, if_id_wren=0, id_ex_bubble=1, then all wren=1; stall_count=1.
- Same as previous but ex_rd=0 -> no stall; all wren=1, stall_count=0.
- ex_redirect=1 with REDIRECT_BUBBLES=1 -> 2 consecutive cycles with if_id_flush=1 and id_ex_bubble=1, pc_wren=1 throughout, then RUN.
- ex_mc_op=1, mc_done after 5 cycles -> mc_start pulses once, then 5 cycles all wren=0, then all wren=1 on the mc_done cycle; stall_count=6, mc_error=0.
- MC_TIMEOUT=8, mc_done never asserted -> mc_error=1 on cycle 8, pipeline resumes; next mc op runs normally and mc_error stays 1.
- reset_n dropped mid MC_WAIT, asynchronously between clock edges -> outputs go to reset values immediately; after release, state=RUN, stall_count=0, mc_error=0.
